// File: rtl/mem_io_responder_pkg.sv
// Shared types and constants for the memory/IO responder: FSM states, decode results,
// I/O register offsets and default region bases.
package mem_io_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   typedef enum logic [2:0] {
      DecRam,
      DecGpioOut,
      DecGpioIn,
      DecCount,
      DecErr
   } decode_e;

   localparam logic [31:0] GpioOutOfs     = 32'h0000_0000;
   localparam logic [31:0] GpioInOfs      = 32'h0000_0004;
   localparam logic [31:0] CountOfs       = 32'h0000_0008;
   localparam logic [31:0] DefaultRamBase = 32'h1001_0000;
   localparam logic [31:0] DefaultIoBase  = 32'h1001_0400;

endpackage

// File: rtl/mem_io_responder_if.sv
// Request/response bus between the core's main controller (master) and the memory/IO
// responder (slave).
interface mem_io_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, addr, wdata, input ready, rdata, err);
   modport slave  (input req, we, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/mem_io_responder_sync_2ff.sv
// Two-flop synchroniser for asynchronous multi-bit level inputs (bits are independent).
module sync_2ff #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Bus responder serving a word-addressed data RAM and a three-register I/O window,
// with programmable wait states and a one-cycle ready pulse per access.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int unsigned RAM_AW      = 6,
   parameter logic [31:0] RAM_BASE    = DefaultRamBase,
   parameter logic [31:0] IO_BASE     = DefaultIoBase,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned GPIO_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_io_responder_if.slave bus,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in
);

   localparam logic [32:0] RamEnd = {1'b0, RAM_BASE} + (33'd4 << RAM_AW);

   state_e      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        accept;
   logic        in_resp;
   logic [31:0] addr_q, wdata_q;
   logic        we_q;
   logic [15:0] count_q;
   decode_e     dec;

   logic [GPIO_W-1:0] gpio_in_sync;
   logic [31:0]       mem [2**RAM_AW];
   logic [31:0]       ram_rdata;
   logic [RAM_AW-1:0] ram_rd_idx;

   sync_2ff #(
      .WIDTH(GPIO_W)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (gpio_in),
      .q    (gpio_in_sync)
   );

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               accept  = 1'b1;
               wait_d  = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
            end
         end
         StWait: begin
            wait_d = wait_q - 4'd1;
            if (wait_q <= 4'd1) state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wait_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
         end
      end
   end

   assign in_resp = (state_q == StResp);

   always_comb begin
      dec = DecErr;
      if (addr_q[1:0] == 2'b00) begin
         if (addr_q >= RAM_BASE && {1'b0, addr_q} < RamEnd) dec = DecRam;
         else if (addr_q == IO_BASE + GpioOutOfs)           dec = DecGpioOut;
         else if (addr_q == IO_BASE + GpioInOfs)            dec = DecGpioIn;
         else if (addr_q == IO_BASE + CountOfs)             dec = DecCount;
         // GPIO_IN and COUNT are read-only
         if (we_q && (dec == DecGpioIn || dec == DecCount)) dec = DecErr;
      end
   end

   // With no wait states the read is issued straight from the bus in the accepting cycle.
   assign ram_rd_idx = accept ? bus.addr[RAM_AW+1:2] : addr_q[RAM_AW+1:2];

   always_ff @(posedge clk) begin
      if (state_d == StResp && !in_resp) ram_rdata <= mem[ram_rd_idx];
      if (in_resp && we_q && dec == DecRam) mem[addr_q[RAM_AW+1:2]] <= wdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_out <= '0;
         count_q  <= '0;
      end else if (in_resp) begin
         count_q <= count_q + 16'd1;
         if (we_q && dec == DecGpioOut) gpio_out <= wdata_q[GPIO_W-1:0];
      end
   end

   assign bus.ready = in_resp;
   assign bus.err   = in_resp && (dec == DecErr);

   always_comb begin
      bus.rdata = '0;
      if (in_resp && !we_q) begin
         unique case (dec)
            DecRam:     bus.rdata = ram_rdata;
            DecGpioOut: bus.rdata = 32'(gpio_out);
            DecGpioIn:  bus.rdata = 32'(gpio_in_sync);
            DecCount:   bus.rdata = {16'h0000, count_q};
            default:    bus.rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: one instance with one wait state, one with none,
// expected responses queued at request time and compared when ready arrives.
module tb_mem_io_responder;
   import mem_io_pkg::*;

   localparam logic [31:0] IoBase  = 32'h1001_0400;
   localparam logic [31:0] RamBase = 32'h1001_0000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] gpio_in1 = '0, gpio_in0 = '0;
   logic [7:0] gpio_out1, gpio_out0;

   mem_io_responder_if bus1 ();
   mem_io_responder_if bus0 ();

   mem_io_responder #(.WAIT_CYCLES(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus1.slave),
      .gpio_out(gpio_out1),
      .gpio_in (gpio_in1)
   );

   mem_io_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus0.slave),
      .gpio_out(gpio_out0),
      .gpio_in (gpio_in0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] mc1 = '0, mc0 = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
      if (sel) begin
         bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d;
      end else begin
         bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? bus1.ready : bus0.ready;
   endfunction

   function automatic logic [31:0] rd(input bit sel);
      return sel ? bus1.rdata : bus0.rdata;
   endfunction

   function automatic logic er(input bit sel);
      return sel ? bus1.err : bus0.err;
   endfunction

   // Waits (bounded) for ready; returns posedges counted since the request was driven.
   task automatic wait_ready(input bit sel, output int lat);
      bit got = 0;
      lat = 0;
      while (!got && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (rdy(sel)) got = 1;
      end
      if (!got) lat = 99;
   endtask

   task automatic access(input bit sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rdata,
                         input logic exp_err, input string tag);
      exp_t e;
      int   lat;
      @(negedge clk);
      drive(sel, 1'b1, w, a, d);
      sb.push_back('{rdata: exp_rdata, err: exp_err});
      wait_ready(sel, lat);
      chk({tag, "_lat"}, 32'(lat), sel ? 32'd2 : 32'd1);
      e = sb.pop_front();
      chk({tag, "_rdata"}, rd(sel), e.rdata);
      chk({tag, "_err"}, 32'(er(sel)), 32'(e.err));
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {31'd0, rdy(sel)}, 32'd0);
      chk({tag, "_idle_rdata"}, rd(sel), 32'd0);
      if (sel) mc1++;
      else mc0++;
   endtask

   initial begin
      int lat;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, bus1.ready}, 32'd0);
      chk("rst_rdata", bus1.rdata, 32'd0);
      chk("rst_err", {31'd0, bus1.err}, 32'd0);
      chk("rst_gpio", 32'(gpio_out1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      access(1, 1, RamBase, 32'h0, 32'h0, 0, "wr_word0");
      access(1, 1, 32'h1001_0010, 32'hDEAD_BEEF, 32'h0, 0, "wr_ram");
      access(1, 0, 32'h1001_0010, 32'h0, 32'hDEAD_BEEF, 0, "rd_ram");
      access(1, 1, IoBase, 32'h0000_01A5, 32'h0, 0, "wr_gpio");
      chk("gpio_out_a5", 32'(gpio_out1), 32'h0000_00A5);
      access(1, 0, IoBase, 32'h0, 32'h0000_00A5, 0, "rd_gpio_out");

      @(negedge clk);
      gpio_in1 = 8'h3C;
      repeat (3) @(posedge clk);
      access(1, 0, IoBase + 32'h4, 32'h0, 32'h0000_003C, 0, "rd_gpio_in");

      access(1, 0, 32'h1001_0012, 32'h0, 32'h0, 1, "err_misalign");
      access(1, 1, 32'h2000_0000, 32'h1111_1111, 32'h0, 1, "err_unmapped");
      access(1, 1, IoBase + 32'h8, 32'hFFFF_FFFF, 32'h0, 1, "err_wr_count");
      access(1, 1, IoBase + 32'h4, 32'hFFFF_FFFF, 32'h0, 1, "err_wr_gpio_in");
      chk("gpio_after_err", 32'(gpio_out1), 32'h0000_00A5);
      access(1, 0, 32'h1001_0010, 32'h0, 32'hDEAD_BEEF, 0, "ram_after_err");
      access(1, 0, IoBase + 32'h8, 32'h0, {16'h0, mc1}, 0, "rd_count");

      // Reset during the wait state of a RAM write
      @(negedge clk);
      drive(1, 1'b1, 1'b1, RamBase, 32'h1234_5678);
      @(posedge clk); #1;
      chk("mid_wait_ready", {31'd0, bus1.ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, bus1.ready}, 32'd0);
      chk("mid_rst_gpio", 32'(gpio_out1), 32'd0);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, '0, '0);
      rst_n = 1'b1;
      mc1 = '0;
      mc0 = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", {31'd0, bus1.ready}, 32'd0);
      end
      access(1, 0, RamBase, 32'h0, 32'h0, 0, "rd_word0_after_rst");
      access(1, 0, IoBase + 32'h8, 32'h0, {16'h0, mc1}, 0, "rd_count_after_rst");

      // Counter wrap
      @(negedge clk);
      force dut1.count_q = 16'hFFFF;
      #1;
      release dut1.count_q;
      mc1 = 16'hFFFF;
      access(1, 0, IoBase + 32'h8, 32'h0, 32'h0000_FFFF, 0, "rd_count_ffff");
      access(1, 0, IoBase + 32'h8, 32'h0, 32'h0000_0000, 0, "rd_count_wrap");

      // Back-to-back: req held across ready
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 32'h1001_0010, '0);
      wait_ready(1, lat);
      chk("b2b_first_lat", 32'(lat), 32'd2);
      chk("b2b_first_rdata", bus1.rdata, 32'hDEAD_BEEF);
      wait_ready(1, lat);
      chk("b2b_second_lat", 32'(lat), 32'd3);
      chk("b2b_second_rdata", bus1.rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, '0, '0);
      mc1 = mc1 + 16'd2;
      access(1, 0, IoBase + 32'h8, 32'h0, {16'h0, mc1}, 0, "rd_count_b2b");

      // Zero wait states
      access(0, 1, 32'h1001_0014, 32'hCAFE_F00D, 32'h0, 0, "w0_wr_ram");
      access(0, 0, 32'h1001_0014, 32'h0, 32'hCAFE_F00D, 0, "w0_rd_ram");
      access(0, 1, IoBase, 32'h0000_005A, 32'h0, 0, "w0_wr_gpio");
      chk("w0_gpio_out", 32'(gpio_out0), 32'h0000_005A);
      access(0, 0, 32'h1001_0100, 32'h0, 32'h0, 1, "w0_err_past_ram");
      access(0, 0, IoBase + 32'h8, 32'h0, {16'h0, mc0}, 0, "w0_rd_count");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
